matmul_apb_master: RTL



---
 rtl/matmul_apb_master.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/matmul_apb_master.sv
// APB4 requester for the matmul accelerator: buffers host commands in a small FIFO,
// runs them as SETUP/ACCESS transfers and returns one response per transfer.
module matmul_apb_master #(
    parameter int MAX_DIM        = 4,
    parameter int BUS_WIDTH      = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
    input  logic [MAX_DIM-1:0]    cmd_strb_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [BUS_WIDTH-1:0]  pwdata_o,
    output logic [MAX_DIM-1:0]    pstrb_o,
    input  logic                  pready_i,
    input  logic                  pslverr_i,
    input  logic [BUS_WIDTH-1:0]  prdata_i,
    output logic                  idle_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1) + 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [BUS_WIDTH-1:0]  wdata;
        logic [MAX_DIM-1:0]    strb;
    } cmd_t;

    cmd_t          fifo_mem [FIFO_DEPTH];
    cmd_t          head;
    logic [PW:0]   wr_ptr, rd_ptr;
    logic          full, empty, push, pop;
    logic          xfer_done, xfer_abort;
    logic [TW-1:0] to_cnt;
    state_t        state_q, state_d;

    // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
    assign full        = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign empty       = (wr_ptr == rd_ptr);
    assign push        = cmd_valid_i && !full;
    assign cmd_ready_o = !full;
    assign head        = fifo_mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr[PW-1:0]] <= '{write: cmd_write_i, addr: cmd_addr_i,
                                          wdata: cmd_wdata_i, strb: cmd_strb_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        xfer_done  = 1'b0;
        xfer_abort = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (pready_i) begin
                    xfer_done = 1'b1;
                    state_d   = RESP;
                end else if (TO_EN && to_cnt == TO_LAST) begin
                    xfer_abort = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counts completed ACCESS cycles; cleared during SETUP so every transfer starts fresh.
    always_ff @(posedge clk_i) begin
        if (rst_i || state_q == SETUP) to_cnt <= '0;
        else if (state_q == ACCESS)    to_cnt <= to_cnt + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pwrite_o <= 1'b0;
            paddr_o  <= '0;
            pwdata_o <= '0;
            pstrb_o  <= '0;
        end else if (pop) begin
            pwrite_o <= head.write;
            paddr_o  <= head.addr;
            pwdata_o <= head.wdata;
            pstrb_o  <= head.write ? head.strb : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
        end else if (xfer_done) begin
            rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
            rsp_err_o     <= pslverr_i;
            rsp_timeout_o <= 1'b0;
        end else if (xfer_abort) begin
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b1;
        end
    end

    assign psel_o      = (state_q == SETUP) || (state_q == ACCESS);
    assign penable_o   = (state_q == ACCESS);
    assign rsp_valid_o = (state_q == RESP);
    assign idle_o      = empty && (state_q == IDLE);

endmodule
